traffic_phase_ctrl: RTL

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/traffic_phase_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic phase controller.
//   phase_e  : signal phase, GREEN=0, YELLOW=1, ALLRED=2
//   LAMP_*   : one-hot {R,Y,G} lamp group values
//   lamp_for : lamp group for one direction given phase and ownership
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Only the direction holding right of way leaves red, and never in ALLRED.
    function automatic logic [2:0] lamp_for(input phase_e ph, input logic owner);
        logic [2:0] lamp;
        lamp = LAMP_R;
        if (owner && ph == GREEN) begin
            lamp = LAMP_G;
        end else if (owner && ph == YELLOW) begin
            lamp = LAMP_Y;
        end
        return lamp;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   en     : count enable; when low the count holds and no tick is produced
//   tick_c : combinational tick, high in the cycle the count wraps
module tick_prescaler #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Gating with en makes a freeze win over a coinciding wrap.
    assign tick_c = en && (cnt_q == LAST);

    // Free-running modulo-CLK_DIV count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Rotating traffic-light phase controller: GREEN -> YELLOW -> ALLRED per
// direction, handing right of way to the next direction after ALLRED.
// Optional pedestrian shortening of green is built when TRAFFIC_PED_REQ_EN
// is defined; otherwise ped_req is present but has no effect.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   pause   : level freeze of prescaler, timer, phase, dir and lamps
//   ped_req : pedestrian request (level)
//   light   : registered lamps, direction d at [3d+2:3d] = {R,Y,G}
//   dir     : direction holding right of way
//   remain  : ticks left in the current phase
//   phase   : current phase (GREEN=0, YELLOW=1, ALLRED=2)
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_DIR   = 2,
    parameter int unsigned CLK_DIV   = 50000000,
    parameter int unsigned GREEN_S   = 20,
    parameter int unsigned YELLOW_S  = 3,
    parameter int unsigned ALLRED_S  = 1,
    parameter int unsigned PED_MIN_S = 5,
    localparam int unsigned DIR_W    = ($clog2(NUM_DIR) > 1) ? $clog2(NUM_DIR) : 1,
    localparam int unsigned MAX_S    = (GREEN_S > YELLOW_S)
                                       ? ((GREEN_S > ALLRED_S) ? GREEN_S : ALLRED_S)
                                       : ((YELLOW_S > ALLRED_S) ? YELLOW_S : ALLRED_S),
    localparam int unsigned CNT_W    = $clog2(MAX_S + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 ped_req,
    output logic [3*NUM_DIR-1:0] light,
    output logic [DIR_W-1:0]     dir,
    output logic [CNT_W-1:0]     remain,
    output logic [1:0]           phase
);

    localparam int unsigned LW = 3 * NUM_DIR;
    localparam logic [LW-1:0] RESET_LIGHT = {{(NUM_DIR - 1){LAMP_R}}, LAMP_G};

    phase_e           phase_q, phase_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [LW-1:0]    light_q, light_d;
    logic             run_c;
    logic             tick_c;
    logic             ped_hit_c;

    assign run_c = !pause;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (run_c),
        .tick_c (tick_c)
    );

`ifdef TRAFFIC_PED_REQ_EN
    // Shorten green only when it would actually shorten it.
    assign ped_hit_c = ped_req && run_c && (phase_q == GREEN)
                       && (rem_q > CNT_W'(PED_MIN_S));
`else
    // Port kept so both builds share one interface.
    logic ped_unused;
    assign ped_unused = ped_req;
    assign ped_hit_c  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= GREEN;
            dir_q   <= '0;
            rem_q   <= CNT_W'(GREEN_S);
            light_q <= RESET_LIGHT;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            light_q <= light_d;
        end
    end

    // Next state, phase timer and lamp decode
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        light_d = '0;

        // Pedestrian load takes priority over a coinciding decrement.
        if (ped_hit_c) begin
            rem_d = CNT_W'(PED_MIN_S);
        end else if (tick_c) begin
            if (rem_q > CNT_W'(1)) begin
                rem_d = rem_q - CNT_W'(1);
            end else begin
                case (phase_q)
                    GREEN: begin
                        phase_d = YELLOW;
                        rem_d   = CNT_W'(YELLOW_S);
                    end
                    YELLOW: begin
                        phase_d = ALLRED;
                        rem_d   = CNT_W'(ALLRED_S);
                    end
                    default: begin
                        phase_d = GREEN;
                        rem_d   = CNT_W'(GREEN_S);
                        dir_d   = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
                    end
                endcase
            end
        end

        // Lamps follow the next phase/dir so they stay aligned with phase.
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
            light_d[3*d +: 3] = lamp_for(phase_d, dir_d == DIR_W'(d));
        end
    end

    assign light  = light_q;
    assign dir    = dir_q;
    assign remain = rem_q;
    assign phase  = phase_q;

endmodule
